// File: rtl/ddr_crc5_engine.sv
// CRC-5 engine for the DDR RX path: serialises each received byte MSB first
// through x^5+x^2+1, with a one-deep hold buffer and deferred finalize.
module ddr_crc5_engine #(
  parameter logic [4:0] P_SEED = 5'h1F,
  parameter logic [4:0] P_POLY = 5'h05
) (
  input  logic       i_sys_clk,
  input  logic       i_sys_rst,
  input  logic       i_en,
  input  logic [7:0] i_data,
  input  logic       i_data_valid,
  input  logic       i_last_byte,
  output logic [4:0] o_crc_value,
  output logic       o_crc_valid,
  output logic       o_busy,
  output logic       o_overrun
);

  // state | meaning
  // IDLE  | no frame open, crc parked at seed
  // SHIFT | one message bit folded into crc per clock
  // ACCUM | between bytes, crc held
  // DONE  | result presented until the next frame starts
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_ACCUM = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0] state_q, state_d;
  logic [4:0] crc_q, crc_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic       last_pend_q, last_pend_d;
  logic [4:0] crc_value_q, crc_value_d;
  logic       crc_valid_q, crc_valid_d;
  logic       busy_q, busy_d;
  logic       overrun_q, overrun_d;

  logic       byte_ok;
  logic       last_ok;
  logic       fb;
  logic [4:0] crc_shift;

  assign byte_ok   = i_en & i_data_valid;
  assign last_ok   = i_en & i_last_byte;
  assign fb        = crc_q[4] ^ shreg_q[bitcnt_q];
  assign crc_shift = {crc_q[3:0], 1'b0} ^ (fb ? P_POLY : 5'h00);

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    shreg_d     = shreg_q;
    bitcnt_d    = bitcnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    last_pend_d = last_pend_q;
    overrun_d   = overrun_q;

    case (state_q)
      S_IDLE: begin
        crc_d = P_SEED;
        if (byte_ok) begin
          shreg_d     = i_data;
          bitcnt_d    = 3'd7;
          last_pend_d = last_ok;
          overrun_d   = 1'b0;
          state_d     = S_SHIFT;
        end else if (last_ok) begin
          state_d = S_DONE;
        end
      end

      S_SHIFT: begin
        if (!i_en) begin
          crc_d       = P_SEED;
          hold_full_d = 1'b0;
          last_pend_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          crc_d = crc_shift;
          if (last_ok) last_pend_d = 1'b1;
          if (byte_ok) begin
            if (hold_full_q) begin
              overrun_d = 1'b1;
            end else begin
              hold_d      = i_data;
              hold_full_d = 1'b1;
            end
          end
          if (bitcnt_q == 3'd0) begin
            // a byte arriving on the last bit with the buffer empty goes straight in
            if (hold_full_q) begin
              shreg_d     = hold_q;
              bitcnt_d    = 3'd7;
              hold_full_d = 1'b0;
            end else if (byte_ok) begin
              shreg_d     = i_data;
              bitcnt_d    = 3'd7;
              hold_full_d = 1'b0;
            end else if (last_pend_q || last_ok) begin
              last_pend_d = 1'b0;
              state_d     = S_DONE;
            end else begin
              state_d = S_ACCUM;
            end
          end else begin
            bitcnt_d = bitcnt_q - 3'd1;
          end
        end
      end

      S_ACCUM: begin
        if (!i_en) begin
          crc_d       = P_SEED;
          last_pend_d = 1'b0;
          state_d     = S_IDLE;
        end else if (byte_ok) begin
          shreg_d     = i_data;
          bitcnt_d    = 3'd7;
          last_pend_d = last_ok;
          state_d     = S_SHIFT;
        end else if (last_ok) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (byte_ok) begin
          crc_d       = P_SEED;
          overrun_d   = 1'b0;
          shreg_d     = i_data;
          bitcnt_d    = 3'd7;
          last_pend_d = last_ok;
          state_d     = S_SHIFT;
        end
      end

      default: begin
        crc_d   = P_SEED;
        state_d = S_IDLE;
      end
    endcase

    crc_valid_d = (state_d == S_DONE);
    crc_value_d = (state_d == S_DONE && state_q != S_DONE) ? crc_d : crc_value_q;
    busy_d      = (state_d == S_SHIFT) | hold_full_d;
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      state_q     <= S_IDLE;
      crc_q       <= P_SEED;
      shreg_q     <= 8'h00;
      bitcnt_q    <= 3'd0;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      last_pend_q <= 1'b0;
      crc_value_q <= 5'h00;
      crc_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      last_pend_q <= last_pend_d;
      crc_value_q <= crc_value_d;
      crc_valid_q <= crc_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign o_crc_value = crc_value_q;
  assign o_crc_valid = crc_valid_q;
  assign o_busy      = busy_q;
  assign o_overrun   = overrun_q;

endmodule

// File: doc/ddr_crc5_engine.md
DDR_CRC5_ENGINE -- requirements
Module: ddr_crc5_engine

Interface
REQ-001 SHALL have parameter P_SEED, default 5'h1F, meaning the CRC register value at the start of each frame.
REQ-002 SHALL have parameter P_POLY, default 5'h05, meaning the feedback taps of x^5+x^2+1 with the x^5 term implicit.
REQ-003 i_sys_clk  input  1  system clock; all logic is on its rising edge.
REQ-004 i_sys_rst  input  1  reset, asynchronous, active-low.
REQ-005 i_en  input  1  engine enable, level-sensitive, driven by the RX deserializer.
REQ-006 i_data  input  8  received byte, sampled only when i_data_valid=1.
REQ-007 i_data_valid  input  1  single-cycle byte strobe.
REQ-008 i_last_byte  input  1  single-cycle finalize request.
REQ-009 o_crc_value  output  5  computed CRC, stable while o_crc_valid=1.
REQ-010 o_crc_valid  output  1  CRC result valid.
REQ-011 o_busy  output  1  high in SHIFT, or while the hold buffer is full.
REQ-012 o_overrun  output  1  sticky flag: a byte was dropped in the current frame.

Function
REQ-013 SHALL implement states IDLE, SHIFT, ACCUM and DONE, with all outputs registered.
REQ-014 IDLE: crc=P_SEED; i_en&i_data_valid -> load shift register with i_data, bitcnt=7, go to SHIFT; i_en&i_last_byte with no data -> DONE with o_crc_value=P_SEED.
REQ-015 SHIFT: one bit per clock, MSB first; fb=crc[4]^bit; crc={crc[3:0],1'b0}^(fb?P_POLY:0); bitcnt decrements each clock.
REQ-016 The acceptance cycle SHALL NOT update crc; the 8 following cycles SHALL each update crc once.
REQ-017 On completion of bit 0 in SHIFT, the next state SHALL be chosen in this priority: (1) hold buffer full -> load the held byte, stay in SHIFT; (2) last_pending -> DONE; (3) otherwise -> ACCUM.
REQ-018 ACCUM: crc held; i_en&i_data_valid -> SHIFT; i_en&i_last_byte -> DONE.
REQ-019 i_data_valid in SHIFT with the hold buffer empty SHALL store the byte in a one-deep hold buffer.
REQ-020 i_data_valid in SHIFT with the hold buffer full SHALL drop the byte and set o_overrun.
REQ-021 i_last_byte in SHIFT SHALL set last_pending; finalize SHALL occur only after the shift register and hold buffer are drained.
REQ-022 i_data_valid and i_last_byte in the same cycle SHALL include the byte first, then finalize.
REQ-023 DONE: o_crc_valid=1 and o_crc_value is held, independent of i_en, so the RX can compare during the CRC field.
REQ-024 i_data_valid&i_en in DONE SHALL start a new frame: reseed to P_SEED, clear o_overrun, clear o_crc_valid, load the byte and go to SHIFT.
REQ-025 i_last_byte in DONE SHALL be ignored.
REQ-026 i_en low in SHIFT or ACCUM SHALL abort to IDLE: hold buffer emptied, last_pending cleared, o_crc_valid=0; o_overrun holds its value.
REQ-027 i_en low in IDLE or DONE SHALL cause no state change.
REQ-028 i_data_valid or i_last_byte with i_en=0 SHALL be ignored in all states.
REQ-029 Latency: for a byte accepted in cycle N with no pending work and last_pending set by cycle N+8, o_crc_valid SHALL rise in cycle N+9.
REQ-030 bitcnt SHALL be 3 bits and SHALL NOT wrap beyond 0 without a reload.

Reset
REQ-031 Asserting i_sys_rst SHALL immediately force IDLE, crc=P_SEED, o_crc_value=5'h00, o_crc_valid=0, o_busy=0, o_overrun=0, hold buffer empty, last_pending=0.
REQ-032 Reset asserted mid-SHIFT SHALL discard all partial state; the first post-reset frame SHALL compute from P_SEED.

Verification
REQ-033 Byte 8'h00, then i_last_byte -> o_crc_value=5'h0F with o_crc_valid=1.
REQ-034 Byte 8'hFF with i_last_byte in the same cycle (cycle N) -> o_crc_valid rises in cycle N+9 with o_crc_value=5'h1B.
REQ-035 Three bytes strobed on consecutive cycles -> byte 1 shifts, byte 2 is held, byte 3 is dropped; o_overrun=1 and o_busy is high for 16 cycles.
REQ-036 i_last_byte with no data in IDLE -> o_crc_value=5'h1F and o_crc_valid=1; a new i_data_valid then clears o_crc_valid within 1 cycle.
REQ-037 i_en dropped in SHIFT after 4 bits -> IDLE; a subsequent frame of byte 8'h00 -> 5'h0F.
REQ-038 Random frames of 1-16 bytes with random gaps and i_en kept high -> o_crc_value matches a bitwise reference model, with no overrun when gaps are at least 8 cycles.
